// File: rtl/v810_bus_slave.sv
// v810_bus_slave: V810 bus-cycle responder with per-region wait states (CLK/RES/CE, CPU bus A/CPU_DI/CPU_DO/BEn/MRQn/RW/BCYSTn/READYn/SZRQn, memory port MA/MD_I/MD_O/MBE/MOE/MWE)
module v810_bus_slave #(
  parameter logic [3:0] WS_32 = 4'd1,
  parameter logic [3:0] WS_16 = 4'd2,
  parameter logic [2:0] BUS16_SEL = 3'h7
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic [31:0] CPU_DI,
  output logic [31:0] CPU_DO,
  input  logic [3:0]  BEn,
  input  logic        MRQn,
  input  logic        RW,
  input  logic        BCYSTn,
  output logic        READYn,
  output logic        SZRQn,
  output logic [31:0] MA,
  input  logic [31:0] MD_I,
  output logic [31:0] MD_O,
  output logic [3:0]  MBE,
  output logic        MOE,
  output logic        MWE
);
  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
  state_t      state;
  logic [31:0] a_q;
  logic        rw_q, mrq_q, r16_q;
  logic [3:0]  cnt;
  logic        idle, start, r16_in, r16, rw, mrq, to_ready;
  logic [3:0]  ws_in, be_in;
  logic [31:0] rdata;
  assign idle     = state == IDLE;
  assign start    = idle & ~BCYSTn;
  assign r16_in   = A[26:24] == BUS16_SEL;
  assign r16      = idle ? r16_in : r16_q;
  assign rw       = idle ? RW : rw_q;
  assign mrq      = idle ? MRQn : mrq_q;
  assign ws_in    = r16_in ? WS_16 : WS_32;
  assign be_in    = r16_in ? {2'b00, A[1] ? ~BEn[3:2] : ~BEn[1:0]} : ~BEn;
  assign rdata    = r16 ? {MD_I[15:0], MD_I[15:0]} : MD_I;
  assign to_ready = start ? ws_in == 4'd0 : (state == WAIT) && (cnt == 4'd1);
  assign MA       = idle ? A : a_q;
  assign MD_O     = r16 ? {CPU_DI[15:0], CPU_DI[15:0]} : CPU_DI;
  always_ff @(posedge CLK) begin
    if (RES) begin
      state  <= IDLE;
      a_q    <= '0;
      rw_q   <= 1'b0;
      mrq_q  <= 1'b1;
      r16_q  <= 1'b0;
      cnt    <= '0;
      READYn <= 1'b1;
      SZRQn  <= 1'b1;
      MWE    <= 1'b0;
      MOE    <= 1'b0;
      MBE    <= '0;
      CPU_DO <= '0;
    end else if (CE) begin
      if (start) begin
        a_q   <= A;
        rw_q  <= RW;
        mrq_q <= MRQn;
        r16_q <= r16_in;
        cnt   <= ws_in;
        MBE   <= be_in;
        MOE   <= RW & ~MRQn;
        state <= ws_in == 4'd0 ? READY : WAIT;
      end
      if (state == WAIT) begin
        cnt   <= cnt - 4'd1;
        state <= cnt == 4'd1 ? READY : WAIT;
      end
      if (state == READY) begin
        state <= IDLE;
        MBE   <= '0;
        MOE   <= 1'b0;
      end
      if (to_ready) CPU_DO <= rdata;
      READYn <= ~to_ready;
      SZRQn  <= ~(to_ready & r16);
      MWE    <= to_ready & ~rw & ~mrq;
    end
  end
endmodule

// File: tb/tb_v810_bus_slave.sv
// tb_v810_bus_slave: directed bench for two v810_bus_slave instances against a phase-count bus model
module tb_v810_bus_slave;
  logic        CLK = 1'b0;
  logic        RES, CE, MRQn, RW, BCYSTn;
  logic [31:0] A, CPU_DI, MD_I;
  logic [3:0]  BEn;
  logic [31:0] cpu_do [2];
  logic [31:0] ma [2];
  logic [31:0] md_o [2];
  logic [3:0]  mbe [2];
  logic        rdy_n [2];
  logic        szrq_n [2];
  logic        moe [2];
  logic        mwe [2];
  int tests = 0, fails = 0, cyc = 0, t1 = 0, wr_cnt = 0;
  bit armed = 1'b0;
  int w32 [2] = '{1, 0};
  int w16 [2] = '{2, 1};
  bit          act [2] = '{1'b0, 1'b0};
  int          k [2] = '{0, 0};
  int          wsm [2] = '{0, 0};
  logic [31:0] la [2];
  logic [31:0] mdo [2];
  logic        lrw [2], lmrq [2], lr16 [2];
  logic [3:0]  lbe [2];

  always #5 CLK = ~CLK;

  v810_bus_slave dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .CPU_DI(CPU_DI), .CPU_DO(cpu_do[0]),
    .BEn(BEn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(rdy_n[0]), .SZRQn(szrq_n[0]),
    .MA(ma[0]), .MD_I(MD_I), .MD_O(md_o[0]), .MBE(mbe[0]), .MOE(moe[0]), .MWE(mwe[0])
  );

  v810_bus_slave #(.WS_32(4'd0), .WS_16(4'd1)) dut0 (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .CPU_DI(CPU_DI), .CPU_DO(cpu_do[1]),
    .BEn(BEn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(rdy_n[1]), .SZRQn(szrq_n[1]),
    .MA(ma[1]), .MD_I(MD_I), .MD_O(md_o[1]), .MBE(mbe[1]), .MOE(moe[1]), .MWE(mwe[1])
  );

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act_v, exp_v, $time);
    end
  endtask

  // Model: k counts CE edges since T1; cycles k=1..ws are waits, k=ws+1 is the ready cycle.
  always @(posedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (RES) begin
        act[i] = 1'b0;
        k[i] = 0;
        mdo[i] = '0;
      end else if (CE) begin
        if (act[i]) begin
          if (k[i] == wsm[i] + 1) act[i] = 1'b0;
          else begin
            k[i]++;
            if (k[i] == wsm[i] + 1) mdo[i] = lr16[i] ? {MD_I[15:0], MD_I[15:0]} : MD_I;
          end
        end else if (!BCYSTn) begin
          act[i] = 1'b1;
          k[i] = 1;
          la[i] = A;
          lrw[i] = RW;
          lbe[i] = BEn;
          lmrq[i] = MRQn;
          lr16[i] = A[26:24] == 3'h7;
          wsm[i] = lr16[i] ? w16[i] : w32[i];
          if (wsm[i] == 0) mdo[i] = lr16[i] ? {MD_I[15:0], MD_I[15:0]} : MD_I;
        end
      end
    end
    if (RES) armed = 1'b1;
  end

  always @(negedge CLK) begin
    if (CE && mwe[0] === 1'b1) wr_cnt++;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        logic rdy, cr16;
        logic [3:0] lanes;
        rdy = act[i] && k[i] == wsm[i] + 1;
        cr16 = act[i] ? lr16[i] : (A[26:24] == 3'h7);
        lanes = lr16[i] ? (la[i][1] ? {2'b00, ~lbe[i][3:2]} : {2'b00, ~lbe[i][1:0]}) : ~lbe[i];
        chk($sformatf("cmp_readyn[%0d]", i), rdy_n[i], !rdy);
        chk($sformatf("cmp_szrqn[%0d]", i), szrq_n[i], !(rdy && lr16[i]));
        chk($sformatf("cmp_mwe[%0d]", i), mwe[i], rdy && !lrw[i] && !lmrq[i]);
        chk($sformatf("cmp_moe[%0d]", i), moe[i], act[i] && lrw[i] && !lmrq[i]);
        chk($sformatf("cmp_mbe[%0d]", i), mbe[i], act[i] ? lanes : 4'd0);
        chk($sformatf("cmp_cpu_do[%0d]", i), cpu_do[i], mdo[i]);
        chk($sformatf("cmp_ma[%0d]", i), ma[i], act[i] ? la[i] : A);
        chk($sformatf("cmp_md_o[%0d]", i), md_o[i], cr16 ? {CPU_DI[15:0], CPU_DI[15:0]} : CPU_DI);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic start(input logic [31:0] a, input logic rw, input logic [3:0] be, input logic mrq, input logic [31:0] di);
    tick();
    A = a;
    RW = rw;
    BEn = be;
    MRQn = mrq;
    CPU_DI = di;
    BCYSTn = 1'b0;
    t1 = cyc;
  endtask

  task automatic wait_rdy(input int exp_d, input string nm);
    bit hit = 1'b0;
    for (int n = 0; n < 30 && !hit; n++) begin
      @(negedge CLK);
      if (rdy_n[0] === 1'b0) hit = 1'b1;
    end
    chk(nm, hit ? 32'(cyc - t1) : 32'hFFFF_FFFF, 32'(exp_d));
  endtask

  initial begin
    int wc;
    RES = 1'b1; CE = 1'b1; BCYSTn = 1'b0; A = 32'h0500_0004; RW = 1'b1;
    BEn = 4'h0; MRQn = 1'b0; CPU_DI = '0; MD_I = '0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_readyn", rdy_n[0], 1'b1);
    chk("rst_szrqn", szrq_n[0], 1'b1);
    chk("rst_mwe", mwe[0], 1'b0);
    chk("rst_moe", moe[0], 1'b0);
    chk("rst_mbe", mbe[0], 4'h0);
    chk("rst_cpu_do", cpu_do[0], 32'h0);
    tick();
    RES = 1'b0;
    BCYSTn = 1'b1;
    @(negedge CLK);
    chk("rst_release_idle", rdy_n[0], 1'b1);
    // 32-bit read, one wait state
    MD_I = 32'hDEAD_BEEF;
    start(32'h0500_0004, 1'b1, 4'h0, 1'b0, 32'h0);
    tick();
    BCYSTn = 1'b1;
    @(negedge CLK);
    chk("rd32_moe_t1p1", moe[0], 1'b1);
    wait_rdy(2, "rd32_latency");
    chk("rd32_cpu_do", cpu_do[0], 32'hDEAD_BEEF);
    chk("rd32_szrqn", szrq_n[0], 1'b1);
    chk("rd32_moe_ready", moe[0], 1'b1);
    // 16-bit write, two wait states, upper halfword lanes
    tick();
    tick();
    wc = wr_cnt;
    start(32'h0700_0002, 1'b0, 4'b0011, 1'b0, 32'h1234_5678);
    tick();
    BCYSTn = 1'b1;
    wait_rdy(3, "wr16_latency");
    chk("wr16_mbe", mbe[0], 4'b0011);
    chk("wr16_md_o_lo", {16'h0, md_o[0][15:0]}, 32'h5678);
    chk("wr16_mwe", mwe[0], 1'b1);
    chk("wr16_szrqn", szrq_n[0], 1'b0);
    tick();
    tick();
    chk("wr16_one_pulse", wr_cnt - wc, 1);
    // back-to-back zero-wait reads on dut0
    tick();
    A = 32'h0100_0000; RW = 1'b1; MRQn = 1'b0; BEn = 4'h0;
    MD_I = 32'h1111_1111; BCYSTn = 1'b0;
    @(negedge CLK);
    chk("b2b_t1_readyn", rdy_n[1], 1'b1);
    tick();
    MD_I = 32'h2222_2222;
    @(negedge CLK);
    chk("b2b_rdy1", rdy_n[1], 1'b0);
    chk("b2b_data1", cpu_do[1], 32'h1111_1111);
    tick();
    @(negedge CLK);
    chk("b2b_gap", rdy_n[1], 1'b1);
    tick();
    BCYSTn = 1'b1;
    @(negedge CLK);
    chk("b2b_rdy2", rdy_n[1], 1'b0);
    chk("b2b_data2", cpu_do[1], 32'h2222_2222);
    // CE gating: three stalled cycles in the first wait state
    tick();
    tick();
    tick();
    wc = wr_cnt;
    start(32'h0700_0000, 1'b0, 4'b1100, 1'b0, 32'hCAFE_0042);
    tick();
    BCYSTn = 1'b1;
    CE = 1'b0;
    tick();
    tick();
    tick();
    CE = 1'b1;
    wait_rdy(6, "ce_latency");
    chk("ce_mbe", mbe[0], 4'b0011);
    chk("ce_md_o", md_o[0], 32'h0042_0042);
    tick();
    tick();
    chk("ce_one_pulse", wr_cnt - wc, 1);
    // abort a write with reset during its wait state
    tick();
    tick();
    wc = wr_cnt;
    start(32'h0200_0000, 1'b0, 4'h0, 1'b0, 32'h55AA_55AA);
    tick();
    BCYSTn = 1'b1;
    RES = 1'b1;
    tick();
    RES = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      chk("abort_readyn", rdy_n[0], 1'b1);
      chk("abort_mwe", mwe[0], 1'b0);
    end
    chk("abort_no_write", wr_cnt - wc, 0);
    // BCYSTn asserted during wait states is ignored
    tick();
    tick();
    MD_I = 32'h0BAD_F00D;
    start(32'h0700_0000, 1'b1, 4'h0, 1'b0, 32'h0);
    tick();
    A = 32'h0300_0000;
    @(negedge CLK);
    chk("viol_ma_t1p1", ma[0], 32'h0700_0000);
    tick();
    @(negedge CLK);
    chk("viol_ma_t1p2", ma[0], 32'h0700_0000);
    chk("viol_readyn_t1p2", rdy_n[0], 1'b1);
    tick();
    BCYSTn = 1'b1;
    @(negedge CLK);
    chk("viol_ready_t1p3", rdy_n[0], 1'b0);
    chk("viol_cpu_do", cpu_do[0], 32'hF00D_F00D);
    tick();
    @(negedge CLK);
    chk("viol_no_restart", rdy_n[0], 1'b1);
    chk("viol_idle_moe", moe[0], 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/v810_bus_slave.md
# v810_bus_slave

Synchronous bus-cycle responder on the external V810 bus. It consumes the bus cycles produced by the CPU core's memory unit (A, BCYSTn, RW, BEn, MRQn) and returns READYn and SZRQn with a per-region, parameterised number of wait states. It drives a simple combinational-read memory port (MA/MD/MBE/MWE/MOE). It is the downstream neighbour of the CPU core in the system top level and replaces ad-hoc READYn tie-offs in benches and the FPGA top.

## Interface
- WS_32, default 1: wait states (0..15) for the 32-bit region.
- WS_16, default 2: wait states (0..15) for the 16-bit region.
- BUS16_SEL, default 3'h7: value of A[26:24] that selects the 16-bit region; all other values select the 32-bit region.

Ports:
- CLK  in  1  system clock
- RES  in  1  reset; synchronous, active-high
- CE  in  1  global clock enable; all state advances only when CE=1
- A  in  32  CPU address
- CPU_DI  in  32  write data from CPU (CPU D_O)
- CPU_DO  out  32  read data to CPU (CPU D_I)
- BEn  in  4  CPU byte enables, active-low
- MRQn  in  1  memory request, active-low
- RW  in  1  1=read, 0=write
- BCYSTn  in  1  bus cycle start, active-low
- READYn  out  1  cycle complete, active-low
- SZRQn  out  1  bus sizing request, active-low
- MA  out  32  memory address
- MD_I  in  32  memory read data, combinational from MA
- MD_O  out  32  memory write data
- MBE  out  4  memory byte enables, active-high
- MOE  out  1  memory read strobe
- MWE  out  1  memory write strobe, one CE-qualified cycle

## Operation
- States: IDLE, WAIT, READY.
- IDLE: on CE=1 and BCYSTn=0 (cycle T1), latch A, RW, BEn, MRQn, and region (R16 = A[26:24]==BUS16_SEL). Load the wait counter with WS_16 or WS_32. Go to WAIT if the count is non-zero, otherwise to READY.
- WAIT: decrement the counter each CE cycle. When it reaches 1, go to READY.
- READY: drive READYn=0 for exactly one CE cycle, then return to IDLE. A new BCYSTn in the READY cycle is not accepted; it is accepted from IDLE only.
- MA = A while in IDLE, latched address otherwise. The memory sees the address in T1.
- CPU_DO is a register, loaded on each CE cycle whose next state is READY:
  - 32-bit region: MD_I.
  - R16 region: {MD_I[15:0], MD_I[15:0]}.
  - It holds its value otherwise.
- Write path:
  - MD_O = CPU_DI in the 32-bit region; {CPU_DI[15:0], CPU_DI[15:0]} in the R16 region.
  - MWE=1 only in the READY cycle of a write with latched MRQn=0.
- MBE, in WAIT/READY:
  - 32-bit region: ~BEn (latched).
  - R16 region: {2'b00, ~BEn[1:0]} if A[1]=0, {2'b00, ~BEn[3:2]} if A[1]=1.
  - 0 in IDLE.
- MOE=1 in WAIT/READY of a read with latched MRQn=0.
- SZRQn=0 in the READY cycle when R16=1, else 1. The CPU issues any follow-up halfword cycle itself.
- Non-memory cycles (latched MRQn=1): still complete with READYn after the region's wait count. MOE=0 and MWE=0.
- BCYSTn=0 while in WAIT or READY: ignored, no restart, no error.

## Timing
- Reset values (RES=1 on a CE cycle, effective next edge): state IDLE, READYn=1, SZRQn=1, MWE=0, MOE=0, MBE=0, CPU_DO=0, counter=0.
- RES mid-cycle aborts the cycle. READYn=1 on the next cycle and MWE is never pulsed.
- RES takes priority over CE.
- Latency counts CE cycles from T1. READYn=0 occurs in cycle T1+1+WS, so the total bus cycle is WS+2 cycles including T1.
  - WS=0: READYn=0 in the cycle right after T1. CPU_DO is loaded from MD_I at the end of T1, using MA=A.
- CE=0: all registers hold. READYn/SZRQn/MWE hold their levels, but a write is performed only on the CE=1 READY cycle.
- Back-to-back: BCYSTn=0 in the first IDLE cycle after READY starts the next cycle with no dead cycle.

## Test plan
- Reset: RES=1 for 2 cycles with BCYSTn=0 → READYn=1, SZRQn=1, MWE=0, MBE=0, CPU_DO=0; no cycle starts until RES=0.
- 32-bit read, WS_32=1: A=0x0500_0004, MD_I=0xDEAD_BEEF → READYn=0 exactly at T1+2, SZRQn=1, CPU_DO=0xDEAD_BEEF, MOE=1 in T1+1..T1+2.
- 16-bit write, WS_16=2: A=0x0700_0002, BEn=4'b0011, CPU_DI=0x1234_5678 → MBE=4'b0011, MD_O[15:0]=0x5678, MWE=1 only at T1+3 with READYn=0 and SZRQn=0.
- WS=0 with back-to-back cycles (WS_32=0): BCYSTn=0 in consecutive T1s → READYn=0 every second cycle; the second read returns the new MD_I value.
- CE gating: CE=0 for 3 cycles mid-WAIT → READYn delayed by exactly 3 cycles; a single MWE CE-cycle.
- Abort and protocol violation:
  - RES=1 in WAIT of a write → no MWE; READYn=1 next cycle.
  - Separately, BCYSTn=0 during WAIT → the cycle completes on its original schedule and the address is unchanged.
